// File: rtl/hilo_muldiv_ctrl_if.sv
// Request/response bundle between the pipeline (master) and the HI/LO multiply/divide sequencer (slave).
interface hilo_muldiv_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             cancel;
    logic             busy;
    logic             wlohi;
    logic [1:0]       c3;
    logic [WIDTH-1:0] in_hi;
    logic [WIDTH-1:0] in_lo;

    modport master (
        output start, op, rs, rt, cancel,
        input  busy, wlohi, c3, in_hi, in_lo
    );

    modport slave (
        input  start, op, rs, rt, cancel,
        output busy, wlohi, c3, in_hi, in_lo
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative 32-step shift-add multiplier / restoring divider that owns every write into HI/LO.
// MTHI/MTLO bypass the datapath and go straight to the write-back cycle.
module hilo_muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    hilo_muldiv_ctrl_if.slave bus
);
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] SEL_BOTH = 2'b10;
    localparam logic [1:0] SEL_HI   = 2'b01;
    localparam logic [1:0] SEL_LO   = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_WB
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             is_div_q, is_div_d;
    logic             busy_q, busy_d;
    logic             wlohi_q, wlohi_d;
    logic [1:0]       c3_q, c3_d;
    logic [WIDTH-1:0] in_hi_q, in_hi_d;
    logic [WIDTH-1:0] in_lo_q, in_lo_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [DW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             signed_op;
    logic             neg_rs;
    logic             neg_rt;
    logic [WIDTH-1:0] mag_rs;
    logic [WIDTH-1:0] mag_rt;

    // Datapath arithmetic: one iteration step, sign fix-up, and operand magnitudes.
    always_comb begin
        mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, b_q};
        div_shift = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_q};
        prod_fix  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo_fix   = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_a_q ? -acc_q[DW-1:WIDTH] : acc_q[DW-1:WIDTH];
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        neg_rs    = signed_op & bus.rs[WIDTH-1];
        neg_rt    = signed_op & bus.rt[WIDTH-1];
        // abs(most-negative) wraps back to itself and is then read as unsigned
        mag_rs    = neg_rs ? -bus.rs : bus.rs;
        mag_rt    = neg_rt ? -bus.rt : bus.rt;
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        a_raw_d  = a_raw_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        is_div_d = is_div_q;
        c3_d     = c3_q;
        in_hi_d  = in_hi_q;
        in_lo_d  = in_lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    unique case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            neg_a_d  = neg_rs;
                            neg_b_d  = neg_rt;
                            b_d      = mag_rs;
                            acc_d    = {{WIDTH{1'b0}}, mag_rt};
                            cnt_d    = CW'(WIDTH - 1);
                            is_div_d = 1'b0;
                            state_d  = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            neg_a_d  = neg_rs;
                            neg_b_d  = neg_rt;
                            b_d      = mag_rt;
                            a_raw_d  = bus.rs;
                            acc_d    = {{WIDTH{1'b0}}, mag_rs};
                            cnt_d    = CW'(WIDTH - 1);
                            is_div_d = 1'b1;
                            state_d  = S_DIV;
                        end
                        OP_MTHI: begin
                            in_hi_d = bus.rs;
                            c3_d    = SEL_HI;
                            state_d = S_WB;
                        end
                        OP_MTLO: begin
                            in_lo_d = bus.rs;
                            c3_d    = SEL_LO;
                            state_d = S_WB;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[DW-1:1]};
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    // Negative trial difference means restore: keep the shifted remainder
                    acc_d = div_trial[WIDTH]
                          ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                          : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (!is_div_q) begin
                        in_hi_d = prod_fix[DW-1:WIDTH];
                        in_lo_d = prod_fix[WIDTH-1:0];
                    end else if (b_q == '0) begin
                        in_hi_d = a_raw_q;
                        in_lo_d = '1;
                    end else begin
                        in_hi_d = rem_fix;
                        in_lo_d = quo_fix;
                    end
                    c3_d    = SEL_BOTH;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        wlohi_d = (state_d == S_WB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            a_raw_q  <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            wlohi_q  <= 1'b0;
            c3_q     <= SEL_LO;
            in_hi_q  <= '0;
            in_lo_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            a_raw_q  <= a_raw_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            is_div_q <= is_div_d;
            busy_q   <= busy_d;
            wlohi_q  <= wlohi_d;
            c3_q     <= c3_d;
            in_hi_q  <= in_hi_d;
            in_lo_q  <= in_lo_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.wlohi = wlohi_q;
    assign bus.c3    = c3_q;
    assign bus.in_hi = in_hi_q;
    assign bus.in_lo = in_lo_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: vector table through a scoreboard, plus cancel/reset/stall sequences.
module tb_hilo_muldiv_ctrl;
    localparam int unsigned WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef struct {
        logic [1:0]  c3;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        exp_t        e;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wr_count = 0;
    int   exp_writes = 0;
    exp_t sb_q[$];
    vec_t tbl[13];

    hilo_muldiv_ctrl_if #(.WIDTH(WIDTH)) bus ();

    hilo_muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Every HILO write pulse seen by the pipeline
    always @(posedge clk) begin
        if (bus.wlohi === 1'b1) wr_count <= wr_count + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one request, waits for its write, ends at the negedge after WB.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input int lat);
        int   k;
        bit   busy_ok;
        exp_t got;
        bus.start = 1'b1;
        bus.op    = o;
        bus.rs    = a;
        bus.rt    = b;
        sb_q.push_back(e);
        exp_writes++;
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        busy_ok = 1'b1;
        while (bus.wlohi !== 1'b1 && k < 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        check("latency", 64'(k), 64'(lat));
        check("busy_until_wb", 64'(busy_ok), 64'd1);
        check("busy_in_wb", 64'(bus.busy), 64'd1);
        if (bus.wlohi === 1'b1 && sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check("c3", 64'(bus.c3), 64'(got.c3));
            if (got.c3 != 2'b00) check("in_hi", 64'(bus.in_hi), 64'(got.hi));
            if (got.c3 != 2'b01) check("in_lo", 64'(bus.in_lo), 64'(got.lo));
        end
        @(negedge clk);
        check("wlohi_drop", 64'(bus.wlohi), 64'd0);
        check("busy_drop", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int   base;
        exp_t e;

        tbl[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '{2'b10, 32'hFFFFFFFE, 32'h00000001}, 34};
        tbl[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFF1}, 34};
        tbl[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFD}, 34};
        tbl[3]  = '{OP_DIVU,  32'd7,        32'd2,        '{2'b10, 32'd1,        32'd3},        34};
        tbl[4]  = '{OP_DIVU,  32'd7,        32'd0,        '{2'b10, 32'd7,        32'hFFFFFFFF}, 34};
        tbl[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, '{2'b10, 32'd0,        32'h80000000}, 34};
        tbl[6]  = '{OP_MTHI,  32'h00001234, 32'd0,        '{2'b01, 32'h00001234, 32'd0},        1};
        tbl[7]  = '{OP_MTLO,  32'h00005678, 32'd0,        '{2'b00, 32'd0,        32'h00005678}, 1};
        tbl[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, '{2'b10, 32'h40000000, 32'h00000000}, 34};
        tbl[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, '{2'b10, 32'd1,        32'hFFFFFFFD}, 34};
        tbl[10] = '{OP_MULT,  32'd7,        32'hFFFFFFFF, '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFF9}, 34};
        tbl[11] = '{OP_DIV,   32'h80000000, 32'd0,        '{2'b10, 32'h80000000, 32'hFFFFFFFF}, 34};
        tbl[12] = '{OP_MULTU, 32'h00010000, 32'h00010000, '{2'b10, 32'd1,        32'd0},        34};

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.rs     = '0;
        bus.rt     = '0;
        bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(bus.busy),  64'd0);
        check("rst_wlohi", 64'(bus.wlohi), 64'd0);
        check("rst_c3",    64'(bus.c3),    64'd0);
        check("rst_in_hi", 64'(bus.in_hi), 64'd0);
        check("rst_in_lo", 64'(bus.in_lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back: each request is driven in the cycle the previous one returns to IDLE
        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].e, tbl[i].lat);
        end

        // Unused opcode: nothing happens
        base = wr_count;
        bus.start = 1'b1;
        bus.op    = 3'd6;
        bus.rs    = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b0;
        check("op6_busy", 64'(bus.busy), 64'd0);
        repeat (4) @(negedge clk);
        check("op6_no_write", 64'(wr_count - base), 64'd0);
        check("op6_hi_kept", 64'(bus.in_hi), 64'd1);

        // Cancel mid-MULT
        base = wr_count;
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.rs    = 32'd9;
        bus.rt    = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy", 64'(bus.busy), 64'd0);
        repeat (40) @(negedge clk);
        check("cancel_no_write", 64'(wr_count - base), 64'd0);

        // Start while busy is ignored
        base = wr_count;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.rs    = 32'd6;
        bus.rt    = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.rs    = 32'hBAD0BAD0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        check("stall_one_write", 64'(wr_count - base), 64'd1);
        check("stall_hi", 64'(bus.in_hi), 64'd0);
        check("stall_lo", 64'(bus.in_lo), 64'd42);
        exp_writes++;

        // Reset mid-DIV, then a fresh DIVU
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.rs    = 32'd100;
        bus.rt    = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy",  64'(bus.busy),  64'd0);
        check("mid_rst_wlohi", 64'(bus.wlohi), 64'd0);
        check("mid_rst_c3",    64'(bus.c3),    64'd0);
        check("mid_rst_in_hi", 64'(bus.in_hi), 64'd0);
        check("mid_rst_in_lo", 64'(bus.in_lo), 64'd0);
        @(negedge clk);
        e = '{2'b10, 32'd2, 32'd14};
        run_op(OP_DIVU, 32'd100, 32'd7, e, 34);

        repeat (3) @(negedge clk);
        check("total_writes", 64'(wr_count), 64'(exp_writes));
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
